// File: rtl/sequential_divider_pkg.sv
// Shared arithmetic definitions for the sequential divider.
// State encoding, default width and result constants.
package sequential_divider_pkg;

  localparam int WIDTH_DEF = 32;

  localparam int CNT_W_DEF = $clog2(WIDTH_DEF) + 1;

  localparam logic [WIDTH_DEF-1:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/sequential_divider_if.sv
// Start/done handshake bundle between the arithmetic unit
// and the sequential divider.
interface sequential_divider_if
  #(parameter int WIDTH = sequential_divider_pkg::WIDTH_DEF);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;
  logic             done;

  modport master (
    output start, is_signed, dividend, divisor,
    input  quotient, remainder, div_by_zero, busy, done
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output quotient, remainder, div_by_zero, busy, done
  );

endinterface

// File: rtl/cond_negate.sv
// Combinational conditional two's-complement negate.
// Shared by the divider and the shift-add multiplier.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = en ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/sequential_divider.sv
// Restoring divider, one quotient bit per clock.
// Signs are stripped on entry and reapplied in FINISH.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic                clk,
  input logic                rst_n,
  sequential_divider_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_n;
  logic [WIDTH:0]   rem_q, rem_n;
  logic [WIDTH-1:0] acc_q, acc_n;
  logic [WIDTH-1:0] dvs_q, dvs_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             q_neg_q, q_neg_n;
  logic             r_neg_q, r_neg_n;
  logic             zero_q, zero_n;
  logic [WIDTH-1:0] quot_q, quot_n;
  logic [WIDTH-1:0] remd_q, remd_n;
  logic             done_q, done_n;
  logic             dbz_q, dbz_n;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] q_fin, r_fin;
  logic [WIDTH:0]   shifted, trial;

  assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];

  cond_negate #(.WIDTH(WIDTH)) u_dvd (
    .en(a_neg), .a(bus.dividend), .y(dvd_mag)
  );

  cond_negate #(.WIDTH(WIDTH)) u_dvs (
    .en(b_neg), .a(bus.divisor), .y(dvs_mag)
  );

  cond_negate #(.WIDTH(WIDTH)) u_quo (
    .en(q_neg_q), .a(acc_q), .y(q_fin)
  );

  cond_negate #(.WIDTH(WIDTH)) u_rem (
    .en(r_neg_q), .a(rem_q[WIDTH-1:0]), .y(r_fin)
  );

  // Remainder stays below the divisor, so the shift never loses a set bit.
  assign shifted = (rem_q << 1)
                 | {{WIDTH{1'b0}}, acc_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    acc_n   = acc_q;
    dvs_n   = dvs_q;
    cnt_n   = cnt_q;
    q_neg_n = q_neg_q;
    r_neg_n = r_neg_q;
    zero_n  = zero_q;
    quot_n  = quot_q;
    remd_n  = remd_q;
    done_n  = done_q;
    dbz_n   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          done_n  = 1'b0;
          dbz_n   = 1'b0;
          q_neg_n = a_neg ^ b_neg;
          r_neg_n = a_neg;
          if (bus.divisor == '0) begin
            zero_n  = 1'b1;
            acc_n   = bus.dividend;
            state_n = FINISH;
          end else begin
            zero_n  = 1'b0;
            acc_n   = dvd_mag;
            dvs_n   = dvs_mag;
            rem_n   = '0;
            cnt_n   = '0;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        rem_n = trial[WIDTH] ? shifted : trial;
        acc_n = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_n = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_n = FINISH;
        end
      end
      FINISH: begin
        // acc_q still holds the raw dividend on divide-by-zero.
        if (zero_q) begin
          quot_n = {WIDTH{DBZ_QUOT[0]}};
          remd_n = acc_q;
          dbz_n  = 1'b1;
        end else begin
          quot_n = q_fin;
          remd_n = r_fin;
        end
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
      acc_q   <= acc_n;
      dvs_q   <= dvs_n;
      cnt_q   <= cnt_n;
      q_neg_q <= q_neg_n;
      r_neg_q <= r_neg_n;
      zero_q  <= zero_n;
      quot_q  <= quot_n;
      remd_q  <= remd_n;
      done_q  <= done_n;
      dbz_q   <= dbz_n;
    end
  end

  assign bus.quotient    = quot_q;
  assign bus.remainder   = remd_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for the sequential divider: results,
// latency, handshake corner cases and async reset.
module tb_sequential_divider;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sequential_divider_if #(.WIDTH(32)) bus ();

  sequential_divider #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic start_op(input logic sgn,
                          input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int lat0,
                           output int lat,
                           output logic bok);
    lat = lat0;
    bok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) bok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.busy) bok = 1'b0;
  endtask

  task automatic do_op(input string tag,
                       input logic sgn,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] eq,
                       input logic [31:0] er,
                       input logic edbz,
                       input int elat);
    int   lat;
    logic bok;
    start_op(sgn, a, b);
    check({tag, "/done_clr"}, 32'(bus.done), 32'd0);
    wait_done(0, lat, bok);
    check({tag, "/lat"}, 32'(lat), 32'(elat));
    check({tag, "/q"}, bus.quotient, eq);
    check({tag, "/r"}, bus.remainder, er);
    check({tag, "/dbz"}, 32'(bus.div_by_zero), 32'(edbz));
    check({tag, "/busy"}, 32'(bok), 32'd1);
  endtask

  initial begin
    int   lat;
    logic bok;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    #12;
    check("rst/q", bus.quotient, 32'd0);
    check("rst/r", bus.remainder, 32'd0);
    check("rst/busy", 32'(bus.busy), 32'd0);
    check("rst/done", 32'(bus.done), 32'd0);
    check("rst/dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("s100/7", 1, 32'd100, 32'd7,
          32'd14, 32'd2, 0, 33);
    do_op("s-100/7", 1, 32'hFFFF_FF9C, 32'd7,
          32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 33);
    do_op("s100/-7", 1, 32'd100, 32'hFFFF_FFF9,
          32'hFFFF_FFF2, 32'd2, 0, 33);
    do_op("s-100/-7", 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
          32'd14, 32'hFFFF_FFFE, 0, 33);
    do_op("smin/-1", 1, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 32'd0, 0, 33);
    do_op("umax/2", 0, 32'hFFFF_FFFF, 32'd2,
          32'h7FFF_FFFF, 32'd1, 0, 33);
    do_op("umin/max", 0, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 32'h8000_0000, 0, 33);

    do_op("s5/0", 1, 32'd5, 32'd0,
          32'hFFFF_FFFF, 32'd5, 1, 1);
    start_op(0, 32'd7, 32'd2);
    check("dbz_clr", 32'(bus.div_by_zero), 32'd0);
    wait_done(0, lat, bok);
    check("u7/2/q", bus.quotient, 32'd3);
    check("u7/2/r", bus.remainder, 32'd1);
    do_op("u5/0", 0, 32'd5, 32'd0,
          32'hFFFF_FFFF, 32'd5, 1, 1);

    start_op(0, 32'd20, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    start_op(0, 32'd9, 32'd9);
    wait_done(10, lat, bok);
    check("ign/lat", 32'(lat), 32'd33);
    check("ign/q", bus.quotient, 32'd6);
    check("ign/r", bus.remainder, 32'd2);
    check("b2b/done_hi", 32'(bus.done), 32'd1);
    do_op("b2b9/9", 0, 32'd9, 32'd9,
          32'd1, 32'd0, 0, 33);

    start_op(0, 32'd1000, 32'd3);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst/busy", 32'(bus.busy), 32'd0);
    check("arst/done", 32'(bus.done), 32'd0);
    check("arst/q", bus.quotient, 32'd0);
    check("arst/r", bus.remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post1/1", 0, 32'd1, 32'd1,
          32'd1, 32'd0, 0, 33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sequential_divider.md
# sequential_divider

Multi-cycle restoring divider for 32-bit operands, signed or unsigned. It produces a quotient and a remainder. It is the inverse-operation companion to the team's shift-add sequential multiplier and sits beside it in the arithmetic unit with the same start/done handshake. It iterates one quotient bit per clock, handles signs by converting to magnitude, and defines results for divide-by-zero and signed overflow.

## Interface
Parameters:
- WIDTH, 32, operand and result width; must be ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on the rising edge of clk; accepted only while busy=0.
- is_signed  in  1  1 = two's-complement operands; 0 = unsigned; captured with start.
- dividend  in  WIDTH  numerator; captured on an accepted start.
- divisor  in  WIDTH  denominator; captured on an accepted start.
- quotient  out  WIDTH  result; valid while done=1.
- remainder  out  WIDTH  result; valid while done=1.
- div_by_zero  out  1  set with done when the captured divisor was 0.
- busy  out  1  operation in progress.
- done  out  1  level; held from completion until the next accepted start.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE:
  - An accepted start captures the operands and clears done and div_by_zero.
  - If divisor=0, go to FINISH. Otherwise load the magnitudes (negate operands that are negative when is_signed=1), clear the partial remainder and the 6-bit count, and go to RUN.
  - Also latch the sign flags: q_neg = sign(dividend)^sign(divisor) and r_neg = sign(dividend). Both are 0 when unsigned.
- RUN, one iteration per cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude using WIDTH+1 bits.
  - If the result is non-negative, keep the difference and set quotient bit=1; otherwise restore and set the bit to 0.
  - count increments. After WIDTH iterations (count==WIDTH-1 at the edge), go to FINISH.
- FINISH, one cycle:
  - Normal case: quotient = q_neg ? -Qmag : Qmag and remainder = r_neg ? -Rmag : Rmag.
  - Divide-by-zero: quotient = all ones, remainder = dividend as captured, div_by_zero=1.
  - Set done=1 and return to IDLE.
- Arithmetic rules:
  - Division truncates toward zero.
  - A nonzero remainder has the dividend's sign, and |remainder| < |divisor|.
- Signed overflow: MIN / -1 gives quotient=MIN and remainder=0. This falls out of the magnitude path (|MIN| is representable as unsigned) and needs no special-case logic.
- Unsigned mode never negates.

## Timing
- Reset (asynchronous, while rst_n=0): state=IDLE; quotient, remainder, count and the internal registers = 0; done=0, busy=0, div_by_zero=0. Reset mid-RUN aborts the operation with no result.
- Latency is counted in rising edges after the accepted start edge E:
  - Normal: WIDTH iterations plus FINISH, so done=1 after edge E+WIDTH+1 (E+33 at WIDTH=32).
  - Divide-by-zero: done=1 after edge E+1.
- busy=1 from after edge E until the FINISH edge; it is 0 in the same cycle that done rises.
- start while busy=1 is ignored and the operands are not re-captured.
- start in the same cycle done is high is accepted and clears done on that edge. Back-to-back operations therefore have no idle gap.
- Outputs hold their values until the next accepted start. quotient and remainder are not cleared on start; only done and div_by_zero are.

## Structure
- Shared arithmetic package, declaring:
  - the state enum (IDLE, RUN, FINISH);
  - the default WIDTH;
  - the divide-by-zero quotient constant (all ones);
  - the count width, $clog2(WIDTH)+1.
- One natural sub-module, cond_negate: a combinational WIDTH-bit conditional two's-complement negate. It is used for operand magnitudes and for the final sign application, and the multiplier can reuse it.
- Datapath registers: partial remainder (WIDTH+1 bits), shifting dividend/quotient register (WIDTH bits), divisor magnitude, count, and the q_neg/r_neg flags.

## Test plan
- Signed 100 / 7 → quotient=14, remainder=2, div_by_zero=0, done rises exactly 33 edges after the start edge, busy=1 throughout.
- Signed -100 / 7 → quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Signed 100 / -7 → quotient=0xFFFFFFF2, remainder=2.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF / 2 → quotient=0x7FFFFFFF, remainder=1.
- Divide-by-zero, dividend=5 and divisor=0 in both modes → quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done after 1 edge. The next valid start clears div_by_zero.
- Start 20/3 and pulse start with 9/9 at iteration 10 → pulse ignored, result quotient=6, remainder=2. Then start again in the done cycle → done drops on that edge and 9/9 yields quotient=1, remainder=0.
- rst_n low at iteration 15 → asynchronously busy=0, done=0, quotient=0, remainder=0. After release, a new 1/1 start gives quotient=1, remainder=0 with normal latency.
